seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display on Basys3.
- Latches a 16-bit BCD value through a load handshake and applies it only at frame boundaries, so a frame never shows a mix of old and new digits.
- Steps the digit enable and decodes each nibble into segments.
- Provides lamp test and ripple-style leading-zero blanking in the 74LS48 manner.

Parameters:
- PRESCALE, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); minimum legal value 8.
- CNT_W, $clog2(PRESCALE), prescaler counter width (derived; do not override).

Ports:
- clk      input   1   system clock, rising edge
- rst      input   1   asynchronous, active-high reset
- value_i  input   16  four BCD digits; [15:12] = digit 3 (MSD), [3:0] = digit 0
- load_i   input   1   one-cycle strobe; captures value_i into the pending register
- pending_o output 1   high from the cycle after capture until the value is applied
- lt_i     input   1   lamp test, active-high
- rbi_n_i  input   1   ripple-blank input, active-low; 0 = blank leading zeros
- an_o     output  4   digit enables, active-low, one-hot-low while scanning
- seg_o    output  7   segments {a,b,c,d,e,f,g}, active-low (0 = lit)
- frame_o  output  1   one-cycle pulse at each frame boundary

Behaviour:
- Reset values: prescaler=0, idx=0, shadow=0, pend_data=0, pending_o=0, an_o=4'b1111, seg_o=7'b1111111, frame_o=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick asserts when count == PRESCALE-1.
- Digit index:
  - idx advances on tick in the order 0,1,2,3,0…
  - The 3→0 wrap is the frame boundary: frame_o=1 for that cycle.
- Shadow update: at the frame boundary, if pending_o=1, then shadow <= pend_data and pending_o <= 0.
- Load handshake:
  - load_i captures value_i into pend_data; pending_o <= 1.
  - Load while already pending: last value wins; pending_o stays 1.
  - Load coincident with a boundary apply: shadow takes the OLD pend_data, pend_data takes the new value_i, pending_o stays 1.
- Output latency: an_o and seg_o are registered and reflect idx and shadow one cycle after idx changes.
- an_o: bit idx = 0, all other bits = 1.
- Glyphs: codes 0–9 use the package table. Codes 10–15 display blank (1111111) and count as nonzero for blanking purposes.
- Leading-zero blanking:
  - Applies when rbi_n_i=0.
  - Digit k (k=3..1) is blanked (seg 1111111) if shadow digits 3 down to k are all zero.
  - Digit 0 is never blanked, so value 0 displays as "0".
  - rbi_n_i=1 disables blanking.
- lt_i=1:
  - seg_o=7'b0000000 for every digit, overriding blanking and glyph.
  - Scanning continues.
  - Takes effect on the next registered update.
- rbi_n_i and lt_i are sampled every cycle; they do not wait for a frame boundary.
- Reset mid-frame returns all state to the reset values immediately (asynchronous); pending data is lost.

Optional Feature:
- SEG7_DIM_EN defined:
  - Adds input duty_i[2:0].
  - Within each slot, an_o is asserted only while prescaler < ((duty_i+1)*PRESCALE)>>3; otherwise an_o=4'b1111.
  - duty_i=7 gives full brightness.
  - duty_i is sampled at each tick.
- SEG7_DIM_EN undefined: no duty_i port; the anode is asserted for the whole slot.

Decomposition:
- seg7_pkg contains:
  - N_DIGITS=4.
  - SEG7_BLANK=7'b1111111 and SEG7_ALL_ON=7'b0000000.
  - Glyph constants 0–9 = 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Sub-module seg7_glyph: combinational nibble→segment lookup with blank and lamp-test overrides. It is instantiated once, on the idx-selected digit.

Test Plan (PRESCALE=8):
- Reset release, then load 16'h1234 -> pending_o high until the first frame_o; the following frame shows idx0 an=1110 seg=1001100 ("4"), idx1 "3", idx2 "2", idx3 "1"; each slot lasts 8 cycles.
- Load 16'h0007 with rbi_n_i=0 -> digits 3, 2, 1 show seg 1111111 with their anode active; digit 0 shows 0001111. With rbi_n_i=1 the same value shows 0000001 on digits 3–1.
- Load 16'h0000 with rbi_n_i=0 -> digits 3–1 blank; digit 0 shows 0000001.
- Load 16'h1111 mid-frame, then 16'h2222 before the boundary -> the frame in progress still shows the old digits; the next frame shows 2222; 1111 is never displayed.
- Assert load_i in the same cycle as frame_o -> the old pending value is applied and pending_o stays 1; the new value is applied at the next frame_o.
- Assert lt_i during any value -> seg_o=0000000 on all digits from the next cycle; deassert -> glyphs resume. Assert rst mid-slot -> an_o=1111, seg_o=1111111 immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 4-digit 7-segment scan controller.
//   N_DIGITS     : number of multiplexed digits
//   SEG7_BLANK   : all segments off (active-low)
//   SEG7_ALL_ON  : all segments lit (lamp test)
//   SEG7_GLYPH_n : active-low {a,b,c,d,e,f,g} patterns for BCD 0..9
//   seg7_decode  : nibble -> glyph; codes 10..15 decode to blank
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int N_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG7_BLANK  = 7'b1111111;
  localparam seg_t SEG7_ALL_ON = 7'b0000000;

  localparam seg_t SEG7_GLYPH_0 = 7'b0000001;
  localparam seg_t SEG7_GLYPH_1 = 7'b1001111;
  localparam seg_t SEG7_GLYPH_2 = 7'b0010010;
  localparam seg_t SEG7_GLYPH_3 = 7'b0000110;
  localparam seg_t SEG7_GLYPH_4 = 7'b1001100;
  localparam seg_t SEG7_GLYPH_5 = 7'b0100100;
  localparam seg_t SEG7_GLYPH_6 = 7'b0100000;
  localparam seg_t SEG7_GLYPH_7 = 7'b0001111;
  localparam seg_t SEG7_GLYPH_8 = 7'b0000000;
  localparam seg_t SEG7_GLYPH_9 = 7'b0000100;

  function automatic seg_t seg7_decode(input bcd_t code);
    seg_t seg;
    case (code)
      4'd0:    seg = SEG7_GLYPH_0;
      4'd1:    seg = SEG7_GLYPH_1;
      4'd2:    seg = SEG7_GLYPH_2;
      4'd3:    seg = SEG7_GLYPH_3;
      4'd4:    seg = SEG7_GLYPH_4;
      4'd5:    seg = SEG7_GLYPH_5;
      4'd6:    seg = SEG7_GLYPH_6;
      4'd7:    seg = SEG7_GLYPH_7;
      4'd8:    seg = SEG7_GLYPH_8;
      4'd9:    seg = SEG7_GLYPH_9;
      default: seg = SEG7_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// -----------------------------------------------------------------------------
// seg7_glyph
// Combinational nibble -> segment lookup with overrides.
//   nibble_i : BCD code of the selected digit
//   blank_i  : force blank (leading-zero suppression)
//   lt_i     : lamp test, lights every segment; wins over blank_i
//   seg_o    : active-low {a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       lt_i,
  output logic [6:0] seg_o
);

  // Override priority: lamp test, then blanking, then glyph table
  always_comb begin
    if (lt_i) begin
      seg_o = SEG7_ALL_ON;
    end else if (blank_i) begin
      seg_o = SEG7_BLANK;
    end else begin
      seg_o = seg7_decode(nibble_i);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode display.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   value_i   : four BCD digits, [15:12] = MSD
//   load_i    : one-cycle strobe capturing value_i into the pending register
//   pending_o : a captured value waits for the next frame boundary
//   lt_i      : lamp test; rbi_n_i : 0 = blank leading zeros
//   an_o      : active-low digit enables; seg_o : active-low segments
//   frame_o   : one-cycle pulse in the cycle where digit 3 wraps to digit 0
// Optional feature macro SEG7_DIM_EN adds duty_i[2:0] for PWM dimming of
// the anode within each slot.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = $clog2(PRESCALE)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic        load_i,
  output logic        pending_o,
  input  logic        lt_i,
  input  logic        rbi_n_i,
`ifdef SEG7_DIM_EN
  input  logic [2:0]  duty_i,
`endif
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        frame_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pend_q, pend_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_q, frame_d;

  logic             tick_s;
  logic             boundary_s;
  logic [3:0]       digit_s;
  logic             blank_s;
  logic [2:0]       lz_s;       // lz_s[k-1]: shadow digits 3..k all zero
  logic [6:0]       glyph_s;
  logic [3:0]       scan_an_s;

`ifdef SEG7_DIM_EN
  logic [2:0]       duty_q, duty_d;
  logic [31:0]      dim_thr_s;
`endif

  // Prescaler wrap, digit stepping and frame pulse lookahead
  always_comb begin
    tick_s     = (cnt_q == CNT_W'(PRESCALE - 1));
    boundary_s = tick_s && (idx_q == 2'd3);
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
    // frame_o is registered, so it is decided one cycle ahead of the wrap cycle
    frame_d = (cnt_q == CNT_W'(PRESCALE - 2)) && (idx_q == 2'd3);
  end

  // Load handshake and frame-boundary shadow update
  always_comb begin
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (boundary_s && pending_q) begin
      shadow_d  = pend_q;
      pending_d = 1'b0;
    end else begin
      shadow_d  = shadow_q;
    end
    // A load on the apply edge re-arms pending after the old value is taken
    if (load_i) begin
      pend_d    = value_i;
      pending_d = 1'b1;
    end else begin
      pend_d    = pend_q;
    end
  end

  // Digit select and ripple leading-zero detection on the shadow value
  always_comb begin
    lz_s[2] = (shadow_q[15:12] == 4'd0);
    lz_s[1] = lz_s[2] && (shadow_q[11:8] == 4'd0);
    lz_s[0] = lz_s[1] && (shadow_q[7:4] == 4'd0);
    case (idx_q)
      2'd0:    begin digit_s = shadow_q[3:0];   blank_s = 1'b0;    end
      2'd1:    begin digit_s = shadow_q[7:4];   blank_s = lz_s[0]; end
      2'd2:    begin digit_s = shadow_q[11:8];  blank_s = lz_s[1]; end
      2'd3:    begin digit_s = shadow_q[15:12]; blank_s = lz_s[2]; end
      default: begin digit_s = 4'd0;            blank_s = 1'b0;    end
    endcase
    if (rbi_n_i) begin
      blank_s = 1'b0;
    end else begin
      blank_s = blank_s;
    end
  end

  seg7_glyph u_glyph (
    .nibble_i (digit_s),
    .blank_i  (blank_s),
    .lt_i     (lt_i),
    .seg_o    (glyph_s)
  );

  // Next anode and segment values
  always_comb begin
    scan_an_s = ~(4'b0001 << idx_q);
    seg_d     = glyph_s;
`ifdef SEG7_DIM_EN
    duty_d    = tick_s ? duty_i : duty_q;
    dim_thr_s = ((32'(duty_q) + 32'd1) * 32'(PRESCALE)) >> 3;
    if (32'(cnt_q) < dim_thr_s) begin
      an_d = scan_an_s;
    end else begin
      an_d = 4'b1111;
    end
`else
    an_d      = scan_an_s;
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      pend_q    <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= SEG7_BLANK;
      frame_q   <= 1'b0;
`ifdef SEG7_DIM_EN
      duty_q    <= 3'd7;
`endif
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
`ifdef SEG7_DIM_EN
      duty_q    <= duty_d;
`endif
    end
  end

  assign pending_o = pending_q;
  assign an_o      = an_q;
  assign seg_o     = seg_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with PRESCALE = 8. The reference
// model works from elapsed cycle count since reset release: slot = t / 8,
// frame boundary when t % 32 == 31, with a pending/shadow pair updated by
// the load/apply rules.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int PRE   = 8;
  localparam int FRAME = 4 * PRE;

  logic        clk;
  logic        rst;
  logic [15:0] value_i;
  logic        load_i;
  logic        pending_o;
  logic        lt_i;
  logic        rbi_n_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        frame_o;
`ifdef SEG7_DIM_EN
  logic [2:0]  duty_i;
`endif

  seg7_scan_ctrl #(.PRESCALE(PRE)) dut (
    .clk       (clk),
    .rst       (rst),
    .value_i   (value_i),
    .load_i    (load_i),
    .pending_o (pending_o),
    .lt_i      (lt_i),
    .rbi_n_i   (rbi_n_i),
`ifdef SEG7_DIM_EN
    .duty_i    (duty_i),
`endif
    .an_o      (an_o),
    .seg_o     (seg_o),
    .frame_o   (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int          m_t;        // rising edges since reset release
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  logic        m_pending;

  logic [6:0] glyph_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%0b expected=%0b", tag, m_t, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int k,
                                         input logic lt, input logic rbi_n);
    int upper;
    int d;
    upper = int'(sh) >> (4 * k);
    d     = upper % 16;
    if (lt) return 7'b0000000;
    else if (!rbi_n && k != 0 && upper == 0) return 7'b1111111;
    else if (d > 9) return 7'b1111111;
    else return glyph_tab[d];
  endfunction

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    int nib;
    v = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      nib = $urandom_range(0, 19);
      if (nib > 15) nib = 0;
      v = v | (16'(nib) << (4 * k));
    end
    return v;
  endfunction

  // One clock: advance the model across the edge, then compare outputs
  task automatic tick_cycle();
    int         idx_pre;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    @(posedge clk);
    idx_pre = (m_t / PRE) % 4;
    e_an    = 4'(15 - (1 << idx_pre));
    e_seg   = exp_seg(m_shadow, idx_pre, lt_i, rbi_n_i);
    if ((m_t % FRAME) == FRAME - 1 && m_pending) begin
      m_shadow  = m_pend;
      m_pending = 1'b0;
    end
    if (load_i) begin
      m_pend    = value_i;
      m_pending = 1'b1;
    end
    m_t++;
    #1;
    chk("an",      16'(an_o),      16'(e_an));
    chk("seg",     16'(seg_o),     16'(e_seg));
    chk("frame",   16'(frame_o),   16'((m_t % FRAME) == FRAME - 1));
    chk("pending", 16'(pending_o), 16'(m_pending));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic do_load(input logic [15:0] v);
    value_i = v;
    load_i  = 1'b1;
    tick_cycle();
    load_i  = 1'b0;
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < FRAME && (m_t % FRAME) != ph; i++) tick_cycle();
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_shadow  = 16'h0000;
    m_pend    = 16'h0000;
    m_pending = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},      16'(an_o),      16'h000F);
    chk({tag, "_seg"},     16'(seg_o),     16'h007F);
    chk({tag, "_frame"},   16'(frame_o),   16'h0000);
    chk({tag, "_pending"}, 16'(pending_o), 16'h0000);
  endtask

  initial begin
    rst     = 1'b1;
    value_i = 16'h0000;
    load_i  = 1'b0;
    lt_i    = 1'b0;
    rbi_n_i = 1'b1;
`ifdef SEG7_DIM_EN
    duty_i  = 3'd7;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Basic load: 1234 applied at the first boundary
    do_load(16'h1234);
    run(2 * FRAME + 6);

    // Leading-zero blanking on 0007, then blanking disabled
    rbi_n_i = 1'b0;
    do_load(16'h0007);
    run(2 * FRAME);
    rbi_n_i = 1'b1;
    run(FRAME);

    // Zero value: only digit 0 lit
    rbi_n_i = 1'b0;
    do_load(16'h0000);
    run(2 * FRAME);

    // Two loads within one frame: last value wins
    rbi_n_i = 1'b1;
    run_to_phase(10);
    do_load(16'h1111);
    run(5);
    do_load(16'h2222);
    run(2 * FRAME);

    // Load coincident with the frame pulse
    run_to_phase(20);
    do_load(16'h5678);
    run_to_phase(FRAME - 1);
    do_load(16'h4321);
    run(2 * FRAME);

    // Lamp test overrides everything, then glyphs resume
    rbi_n_i = 1'b0;
    do_load(16'h0090);
    run(FRAME);
    lt_i = 1'b1;
    run(12);
    lt_i = 1'b0;
    run(12);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      load_i  = ($urandom_range(0, 15) == 0);
      value_i = rand_val();
      lt_i    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 39) == 0) rbi_n_i = 1'($urandom_range(0, 1));
      tick_cycle();
    end
    load_i = 1'b0;
    lt_i   = 1'b0;

    // Asynchronous reset in the middle of a slot
    do_load(16'h9876);
    run_to_phase(PRE + 3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rbi_n_i = 1'b1;
    do_load(16'h0905);
    run(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
